// File: rtl/trigger_conditioner_if.sv
// -----------------------------------------------------------------------------
// trigger_conditioner_if
// Host programming bus for the trigger conditioner.
//   prog_we       one-cycle write strobe (dataclk domain)
//   prog_module   target module select
//   prog_address  register select (0: debounce length, 1: polarity mask)
//   prog_channel  digital-input index for per-channel registers
//   prog_word     write data
// master drives the bus (host side), slave receives it (conditioner side).
// -----------------------------------------------------------------------------
interface trigger_conditioner_if;
  logic        prog_we;
  logic [4:0]  prog_module;
  logic [3:0]  prog_address;
  logic [3:0]  prog_channel;
  logic [15:0] prog_word;

  modport master (
    output prog_we,
    output prog_module,
    output prog_address,
    output prog_channel,
    output prog_word
  );

  modport slave (
    input prog_we,
    input prog_module,
    input prog_address,
    input prog_channel,
    input prog_word
  );
endinterface

// File: rtl/trigger_conditioner.sv
// -----------------------------------------------------------------------------
// trigger_conditioner
// Builds the 32-bit trigger vector consumed by the stim / digital-output
// sequencers. Once per sample frame (tick = channel 0, main_state TICK_STATE)
// it publishes:
//   triggers[15:0]  debounced, polarity-adjusted external digital inputs
//   triggers[23:16] host manual triggers, edge-captured, one frame long
//   triggers[31:24] synchronized comparator flags
//
// Ports:
//   dataclk       system data clock
//   reset         synchronous, active-high
//   main_state    global sequencer state
//   channel       global channel index
//   digin         asynchronous TTL inputs
//   comp_in       asynchronous comparator flags
//   manual_trig   asynchronous host level triggers
//   prog          programming bus (trigger_conditioner_if.slave)
//   triggers      conditioned trigger vector, updated the cycle after a tick
//   digin_stable  debounced digin before polarity, for host readout
//
// Optional feature, macro TRIGGER_CONDITIONER_STATUS_EN:
//   status_clear  one-cycle pulse clearing trig_seen
//   trig_seen     sticky OR of every published trigger vector
// -----------------------------------------------------------------------------
module trigger_conditioner #(
  parameter int MODULE     = 0,
  parameter int TICK_STATE = 98
) (
  input  logic                 dataclk,
  input  logic                 reset,
  input  logic [31:0]          main_state,
  input  logic [5:0]           channel,
  input  logic [15:0]          digin,
  input  logic [7:0]           comp_in,
  input  logic [7:0]           manual_trig,
  trigger_conditioner_if.slave prog,
`ifdef TRIGGER_CONDITIONER_STATUS_EN
  input  logic                 status_clear,
  output logic [31:0]          trig_seen,
`endif
  output logic [31:0]          triggers,
  output logic [15:0]          digin_stable
);

  localparam logic [4:0]  MODULE_SEL = MODULE[4:0];
  localparam logic [31:0] TICK_VAL   = 32'(TICK_STATE);

  // Two-flop synchronizers.
  logic [15:0] digin_s1, digin_s2;
  logic [7:0]  comp_s1, comp_s2;
  logic [7:0]  man_s1, man_s2;

  // Programmed registers.
  logic [3:0]  deb_len [16];
  logic [15:0] digin_pol;

  // Debounce state.
  logic [15:0] stable, stable_next;
  logic [3:0]  cnt [16];
  logic [3:0]  cnt_next [16];

  // Manual trigger capture.
  logic [7:0]  man_prev;
  logic [7:0]  pend;
  logic [7:0]  man_rise;
  logic [1:0]  warm;
  logic        sync_warm;

  logic        tick;
  logic [31:0] trig_new;

  assign tick         = (channel == 6'd0) && (main_state == TICK_VAL);
  assign digin_stable = stable;

  // The manual synchronizer outputs zeros for two cycles after reset; until
  // it carries the real level, edge history stays at all-ones so a trigger
  // held high through reset is not mistaken for a fresh rising edge.
  assign sync_warm = (warm == 2'd2);
  assign man_rise  = man_s2 & ~man_prev;

  // Next debounce state, only ever advanced on the tick.
  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    stable_next = stable;
    cnt_next    = cnt;
    if (tick) begin
      for (int i = 0; i < 16; i++) begin
        if (digin_s2[i] == stable[i]) begin
          cnt_next[i] = 4'd0;
        end else if (({1'b0, cnt[i]} + 5'd1) >=
                     ((deb_len[i] == 4'd0) ? 5'd1 : {1'b0, deb_len[i]})) begin
          stable_next[i] = digin_s2[i];
          cnt_next[i]    = 4'd0;
        end else begin
          cnt_next[i] = cnt[i] + 4'd1;
        end
      end
    end
  end

  // Manual field carries the pending edges captured before this tick.
  assign trig_new = {comp_s2, pend, stable_next ^ digin_pol};

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its sources regardless of statement order.
  always_ff @(posedge dataclk) begin
    if (reset) begin
      digin_s1  <= '0;
      digin_s2  <= '0;
      comp_s1   <= '0;
      comp_s2   <= '0;
      man_s1    <= '0;
      man_s2    <= '0;
      man_prev  <= 8'hFF;
      warm      <= 2'd0;
      pend      <= '0;
      stable    <= '0;
      digin_pol <= '0;
      triggers  <= '0;
      // NOTE: the small per-channel register arrays are reset explicitly;
      // they are flops with defined defaults, not RAM.
      for (int i = 0; i < 16; i++) begin
        deb_len[i] <= 4'd0;
        cnt[i]     <= 4'd0;
      end
    end else begin
      digin_s1 <= digin;
      digin_s2 <= digin_s1;
      comp_s1  <= comp_in;
      comp_s2  <= comp_s1;
      man_s1   <= manual_trig;
      man_s2   <= man_s1;

      if (!sync_warm) warm <= warm + 2'd1;
      man_prev <= sync_warm ? man_s2 : 8'hFF;

      // An edge on the tick cycle lands after the transfer, so it is carried
      // into the next frame instead of being dropped.
      if (tick) pend <= man_rise;
      else      pend <= pend | man_rise;

      stable <= stable_next;
      cnt    <= cnt_next;
      if (tick) triggers <= trig_new;

      // Register writes are consumed only on the tick, so they take effect at
      // the next frame without extra staging.
      if (prog.prog_we && (prog.prog_module == MODULE_SEL)) begin
        case (prog.prog_address)
          4'd0:    deb_len[prog.prog_channel] <= prog.prog_word[3:0];
          4'd1:    digin_pol <= prog.prog_word;
          default: ;
        endcase
      end
    end
  end

`ifdef TRIGGER_CONDITIONER_STATUS_EN
  // Clear is applied before the OR so a clear on a tick keeps that frame.
  always_ff @(posedge dataclk) begin
    if (reset) begin
      trig_seen <= '0;
    end else if (tick) begin
      trig_seen <= (status_clear ? 32'd0 : trig_seen) | trig_new;
    end else if (status_clear) begin
      trig_seen <= '0;
    end
  end
`endif

endmodule
